// File: rtl/qracc_psum_accumulator_if.sv
// Bit-plane input stream and accumulated-result output stream of the
// QR-ACC partial-sum accumulator.
interface qracc_psum_accumulator_if #(
   parameter int numCols    = 32,
   parameter int numAdcBits = 4,
   parameter int accBits    = 16
);
   logic                                 adc_valid_i;
   logic                                 adc_ready_o;
   logic [numCols-1:0][numAdcBits-1:0]   adc_out_i;
   logic [numCols-1:0][accBits-1:0]      acc_o;
   logic                                 acc_valid_o;
   logic                                 acc_ready_i;
   logic                                 overflow_o;

   modport slave (
      input  adc_valid_i, adc_out_i, acc_ready_i,
      output adc_ready_o, acc_o, acc_valid_o, overflow_o
   );

   modport master (
      output adc_valid_i, adc_out_i, acc_ready_i,
      input  adc_ready_o, acc_o, acc_valid_o, overflow_o
   );
endinterface

// File: rtl/qracc_psum_accumulator.sv
// Accumulates MSB-first signed ADC bit-plane codes per column into saturating
// signed sums, with a one-deep result register and a WAIT hold for backpressure.
module qracc_psum_accumulator #(
   parameter int numCols    = 32,
   parameter int numAdcBits = 4,
   parameter int numCfgBits = 8,
   parameter int accBits    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [numCfgBits-1:0] n_input_bits_cfg,
   input  logic                  start_i,
   output logic                  busy_o,
   qracc_psum_accumulator_if.slave bus
);
   localparam int SW = accBits + 2;
   localparam logic signed [SW-1:0] MAX_V = {3'b000, {(accBits-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_V = {3'b111, {(accBits-1){1'b0}}};
   localparam logic [numCfgBits-1:0] CFG_ONE = numCfgBits'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, WAIT = 2'd2} state_t;

   state_t                          state_r, state_s;
   logic [numCfgBits-1:0]           n_r, cnt_r;
   logic [numCols-1:0][accBits-1:0] work_r, next_work_s, load_data_s, acc_r;
   logic                            ovf_work_r, plane_ovf_s, load_ovf_s, ovf_r, valid_r;
   logic                            start_batch_s, take_plane_s, load_out_s, last_plane_s;
   logic signed [SW-1:0]            ext_v_s, dbl_v_s, sum_v_s;

   function automatic logic over_range(input logic signed [SW-1:0] v);
      return (v > MAX_V) || (v < MIN_V);
   endfunction

   function automatic logic [accBits-1:0] saturate(input logic signed [SW-1:0] v);
      if (v > MAX_V) begin
         return MAX_V[accBits-1:0];
      end else if (v < MIN_V) begin
         return MIN_V[accBits-1:0];
      end else begin
         return v[accBits-1:0];
      end
   endfunction

   assign last_plane_s = (cnt_r == (n_r - CFG_ONE));

   // Per-column plane update; the first plane of a multi-plane batch is the sign plane.
   always_comb begin
      next_work_s = work_r;
      plane_ovf_s = 1'b0;
      ext_v_s     = '0;
      dbl_v_s     = '0;
      sum_v_s     = '0;
      for (int c = 0; c < numCols; c++) begin
         ext_v_s = {{(SW-numAdcBits){bus.adc_out_i[c][numAdcBits-1]}}, bus.adc_out_i[c]};
         dbl_v_s = {work_r[c][accBits-1], work_r[c], 1'b0};
         if (cnt_r == '0) begin
            if (n_r != CFG_ONE) begin
               sum_v_s = -ext_v_s;
            end else begin
               sum_v_s = ext_v_s;
            end
         end else begin
            sum_v_s = dbl_v_s + ext_v_s;
         end
         next_work_s[c] = saturate(sum_v_s);
         plane_ovf_s    = plane_ovf_s | over_range(sum_v_s);
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_s       = state_r;
      start_batch_s = 1'b0;
      take_plane_s  = 1'b0;
      load_out_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               start_batch_s = 1'b1;
               state_s       = ACCUM;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (bus.adc_valid_i) begin
               take_plane_s = 1'b1;
               if (last_plane_s) begin
                  if (!valid_r || bus.acc_ready_i) begin
                     load_out_s = 1'b1;
                     state_s    = IDLE;
                  end else begin
                     state_s = WAIT;
                  end
               end else begin
                  state_s = ACCUM;
               end
            end else begin
               state_s = ACCUM;
            end
         end
         WAIT: begin
            if (bus.acc_ready_i) begin
               load_out_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = WAIT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // The output register loads straight from the final plane or from the held WAIT sums.
   always_comb begin
      if (state_r == ACCUM) begin
         load_data_s = next_work_s;
         load_ovf_s  = ovf_work_r | plane_ovf_s;
      end else begin
         load_data_s = work_r;
         load_ovf_s  = ovf_work_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Working accumulators, plane counter and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_r        <= '0;
         cnt_r      <= '0;
         work_r     <= '0;
         ovf_work_r <= 1'b0;
      end else if (start_batch_s) begin
         n_r        <= (n_input_bits_cfg == '0) ? CFG_ONE : n_input_bits_cfg;
         cnt_r      <= '0;
         work_r     <= '0;
         ovf_work_r <= 1'b0;
      end else if (take_plane_s) begin
         cnt_r      <= cnt_r + CFG_ONE;
         work_r     <= next_work_s;
         ovf_work_r <= ovf_work_r | plane_ovf_s;
      end else begin
         cnt_r      <= cnt_r;
         work_r     <= work_r;
         ovf_work_r <= ovf_work_r;
      end
   end

   // Result register: a load keeps valid high even when the old result is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r   <= '0;
         ovf_r   <= 1'b0;
         valid_r <= 1'b0;
      end else if (load_out_s) begin
         acc_r   <= load_data_s;
         ovf_r   <= load_ovf_s;
         valid_r <= 1'b1;
      end else if (bus.acc_ready_i) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign bus.acc_o       = acc_r;
   assign bus.overflow_o  = ovf_r;
   assign bus.acc_valid_o = valid_r;
   assign bus.adc_ready_o = (state_r == ACCUM);
   assign busy_o          = (state_r != IDLE);
endmodule
